// File: rtl/pipe_link_pkg.sv
// rtl/pipe_link_pkg.sv - shared sizing helpers for the credit-based pipe link
package pipe_link_pkg;

   localparam int DEFAULT_LINK_DEPTH = 4;

   // Width able to hold 0..depth; sizes both the rx level and the sender's credit counter.
   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_credit_rx_mem.sv
// rtl/pipe_credit_rx_mem.sv - DEPTH x ELEM_WIDTH register array, async read, no reset
module pipe_credit_rx_mem #(
   parameter int ELEM_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [ELEM_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [ELEM_WIDTH-1:0] rdata_o
);

   logic [ELEM_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_delay.sv
// rtl/pipe_delay.sv - fixed-latency register chain, NUM_STAGE=0 is a wire
module pipe_delay #(
   parameter int NUM_STAGE  = 1,
   parameter int ELEM_WIDTH = 1,
   parameter bit RESET_EN   = 1'b1
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [ELEM_WIDTH-1:0] data_i,
   output logic [ELEM_WIDTH-1:0] data_o
);

   // Bypass and no-reset builds leave clk/arst_n unread.
   logic unused_ok;
   assign unused_ok = ^{clk, arst_n};

   if (NUM_STAGE == 0) begin : g_bypass
      assign data_o = data_i;
   end else begin : g_chain
      logic [ELEM_WIDTH-1:0] stage_q [NUM_STAGE];

      if (RESET_EN) begin : g_rst
         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
               for (int k = 0; k < NUM_STAGE; k++) stage_q[k] <= '0;
            end else begin
               stage_q[0] <= data_i;
               for (int k = 1; k < NUM_STAGE; k++) stage_q[k] <= stage_q[k-1];
            end
         end
      end else begin : g_norst
         always_ff @(posedge clk) begin
            stage_q[0] <= data_i;
            for (int k = 1; k < NUM_STAGE; k++) stage_q[k] <= stage_q[k-1];
         end
      end

      assign data_o = stage_q[NUM_STAGE-1];
   end

endmodule

// File: rtl/pipe_credit_rx.sv
// rtl/pipe_credit_rx.sv - receive terminator for a fixed-latency pipe: buffers in-flight
// words and returns one credit per consumed word so the sender never overruns DEPTH.
module pipe_credit_rx
   import pipe_link_pkg::*;
#(
   parameter int ELEM_WIDTH    = 32,
   parameter int DEPTH         = DEFAULT_LINK_DEPTH,
   parameter int CREDIT_STAGES = 0
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic                       in_valid,
   input  logic [ELEM_WIDTH-1:0]      in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ELEM_WIDTH-1:0]      out_data,
   output logic                       credit_out,
   output logic [credit_w(DEPTH)-1:0] level,
   output logic                       overflow,
   input  logic                       overflow_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = credit_w(DEPTH);

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;
   logic          credit_q;
   logic          full, pop, push, drop;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full       = (level_q == LW'(DEPTH));
      pop        = (level_q != '0) && out_ready;
      push       = in_valid && (!full || pop);
      drop       = in_valid && full && !pop;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;

      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);

      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      // A new drop outranks a clear arriving in the same cycle.
      if (drop)              overflow_d = 1'b1;
      else if (overflow_clr) overflow_d = 1'b0;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         credit_q   <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         credit_q   <= pop;
      end
   end

   pipe_credit_rx_mem #(
      .ELEM_WIDTH (ELEM_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (out_data)
   );

   pipe_delay #(
      .NUM_STAGE  (CREDIT_STAGES),
      .ELEM_WIDTH (1),
      .RESET_EN   (1'b1)
   ) u_credit_dly (
      .clk    (clk),
      .arst_n (arst_n),
      .data_i (credit_q),
      .data_o (credit_out)
   );

   assign out_valid = (level_q != '0);
   assign level     = level_q;
   assign overflow  = overflow_q;

endmodule

// File: doc/pipe_credit_rx.md
Name: pipe_credit_rx

Overview:
- Receive-end terminator for a fixed-latency, flow-control-free pipelined channel (valid/data delayed by N register stages, no ready).
- Absorbs in-flight words into a FIFO of DEPTH entries and presents a valid/ready interface to the local consumer.
- Returns one credit pulse per consumed word, so the far-end sender (which starts with DEPTH credits) never overruns the buffer, regardless of pipeline length.

Parameters:
- ELEM_WIDTH, 32, data word width.
- DEPTH, 4, buffer entries; any integer >= 2 (not required to be a power of two); equals the sender's initial credit count.
- CREDIT_STAGES, 0, extra register stages on credit_out toward the sender; 0 = credit_out is the base registered pulse.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  word present on in_data this cycle (from the pipeline output).
- in_data  in  ELEM_WIDTH  incoming word.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_data  out  ELEM_WIDTH  head entry data.
- credit_out  out  1  one-cycle pulse per freed entry, sent back to the sender.
- level  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky error: a push arrived while the buffer was full and no pop occurred that cycle.
- overflow_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (arst_n low, async): rd_ptr=0, wr_ptr=0, level=0, out_valid=0, credit_out=0 (including every CREDIT_STAGES stage), overflow=0.
  - out_data is don't-care while out_valid=0; storage array is not reset.
- Push: in_valid=1 and (level<DEPTH or pop this cycle) -> write mem[wr_ptr], wr_ptr advances.
- Pop: out_valid & out_ready -> rd_ptr advances.
- Pointer wrap: both pointers wrap explicitly from DEPTH-1 to 0 (no power-of-two masking).
- level update: +1 on push only, -1 on pop only, unchanged on push+pop.
- Latency: a word pushed in cycle t is visible on out_valid/out_data in cycle t+1. There is no same-cycle bypass when empty.
- out_valid = (level != 0). out_data = mem[rd_ptr], combinational from registered pointer and storage.
- Full and push with simultaneous pop: push accepted into the freed slot; level stays DEPTH; no overflow.
- Full and push without pop: word dropped; pointers and level unchanged; overflow set the next cycle.
- Empty and out_ready=1: no pop, no credit.
- Protocol rule: out_data must stay stable while out_valid=1 and out_ready=0 (guaranteed by design).
- Credits:
  - Base credit pulse = registered pop, asserted in cycle t+1 for a pop in cycle t.
  - credit_out = base pulse delayed by CREDIT_STAGES further cycles, implemented as a reset-clearing shift chain.
  - Back-to-back pops produce back-to-back credit pulses; the total credit count equals the total pop count exactly.
- overflow: set on the dropped-push condition, held until overflow_clr=1 or reset.
  - Set and clear in the same cycle: set wins.
- Reset mid-operation: all contents are discarded. Credits not yet delivered are lost, so the sender must be reset in the same domain and reload DEPTH credits.
- No combinational path from in_valid/in_data to any output. out_ready feeds only registered state.

Decomposition:
- Shared package pipe_link_pkg:
  - function credit_w(depth) = $clog2(depth+1), used by level and by the sender's credit counter.
  - localparam DEFAULT_LINK_DEPTH = 4.
- Sub-module pipe_credit_rx_mem: DEPTH x ELEM_WIDTH register array.
  - Write port: we, waddr, wdata. Asynchronous read port: raddr -> rdata. No reset.
- Credit delay chain: instantiate the team's existing pipeline delay block with NUM_STAGE=CREDIT_STAGES, ELEM_WIDTH=1, reset enabled.

Test Plan:
- Fill and drain: DEPTH=4, CREDIT_STAGES=0.
  - Stimulus: push 0xA0..0xA3 on consecutive cycles with out_ready=0, then out_ready=1.
  - Required: level reaches 4; outputs 0xA0..0xA3 in order; four credit_out pulses, each one cycle after its pop; level returns to 0.
- Full with simultaneous push/pop: level=4, in_valid=1 with 0xB0, out_ready=1.
  - Required: head popped; 0xB0 stored at the tail; level stays 4; overflow=0.
- Overflow: level=4, out_ready=0, push 0xC0.
  - Required: word dropped; level stays 4; overflow=1 next cycle and held.
  - Then overflow_clr pulse -> overflow=0. Set and clear in the same cycle -> overflow stays 1.
- Pointer wrap, DEPTH=3: stream 10 words 0..9 with out_ready toggling 1,0,1,0.
  - Required: output order 0..9, no drops, 10 credits in total.
- Credit delay, CREDIT_STAGES=2: single pop in cycle t.
  - Required: credit_out high in exactly cycle t+3.
- Mid-stream reset: level=2, assert arst_n low asynchronously mid-cycle.
  - Required: out_valid, credit_out, level and overflow go to 0 immediately.
  - After release: a push of 0xD0 appears at the output one cycle later.
